// File: rtl/inst_prefetch_queue.sv
// Fetch-side prefetch queue: one-outstanding sequential fetcher feeding a small PC/word FIFO.
// Define PREFETCH_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module inst_prefetch_queue #(
    parameter int unsigned                INST_ADDR_WIDTH     = 16,
    parameter int unsigned                INST_DATA_BIT_WIDTH = 16,
    parameter int unsigned                NUM_BYTES_IN_INST   = 2,
    parameter int unsigned                QUEUE_DEPTH         = 4,
    parameter int unsigned                PTR_WIDTH           = 2,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_ADDR          = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect,
    input  logic [INST_ADDR_WIDTH-1:0]     redirect_addr,
    input  logic                           halt,
    output logic                           mem_req,
    output logic [INST_ADDR_WIDTH-1:0]     mem_addr,
    input  logic                           mem_ack,
    input  logic [INST_DATA_BIT_WIDTH-1:0] mem_data,
    input  logic                           mem_exc,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [INST_ADDR_WIDTH-1:0]     inst_pc,
    output logic [INST_DATA_BIT_WIDTH-1:0] inst_data,
    output logic                           inst_exc,
    output logic [PTR_WIDTH:0]             queue_count
);

    localparam logic [INST_ADDR_WIDTH-1:0] PcInc    = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
    localparam logic [PTR_WIDTH:0]         DepthCnt = (PTR_WIDTH + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_WIDTH:0]         CntOne   = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0]       PtrOne   = PTR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StReq, StDrain, StStop} state_e;

    state_e                         state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
    logic [INST_ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [PTR_WIDTH-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]             count_q, count_d;

    logic [INST_ADDR_WIDTH-1:0]     pc_mem   [QUEUE_DEPTH];
    logic [INST_DATA_BIT_WIDTH-1:0] data_mem [QUEUE_DEPTH];
    logic                           exc_mem  [QUEUE_DEPTH];

    logic ack_accept, fifo_empty, bypass, pop, do_write, do_read, allowed;

    // An ack only produces a word when no redirect is flushing the stream in the same cycle.
    assign ack_accept = (state_q == StReq) && mem_ack && !redirect;
    assign fifo_empty = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = fifo_empty && ack_accept;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = !fifo_empty || bypass;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign do_write   = ack_accept && !(bypass && inst_ready);
    assign do_read    = pop && !fifo_empty;

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (do_write && !do_read) begin
            count_d = count_q + CntOne;
        end else if (!do_write && do_read) begin
            count_d = count_q - CntOne;
        end
    end

    assign allowed = !halt && (count_d < DepthCnt);

    always_comb begin
        wr_ptr_d   = redirect ? '0 : (do_write ? wr_ptr_q + PtrOne : wr_ptr_q);
        rd_ptr_d   = redirect ? '0 : (do_read ? rd_ptr_q + PtrOne : rd_ptr_q);
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
        end else if (ack_accept) begin
            fetch_pc_d = fetch_pc_q + PcInc;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (allowed) state_d = StReq;
            end
            StReq: begin
                if (redirect) begin
                    state_d = mem_ack ? (allowed ? StReq : StIdle) : StDrain;
                end else if (mem_ack) begin
                    state_d = mem_exc ? StStop : (allowed ? StReq : StIdle);
                end
            end
            // The drained ack ends the stale request even if another redirect lands with it.
            StDrain: begin
                if (mem_ack) state_d = allowed ? StReq : StIdle;
            end
            StStop: begin
                if (redirect) state_d = allowed ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_req  = (state_q == StReq) || (state_q == StDrain);
        mem_addr = mem_addr_q;
    end

    // The address register only loads on entry to (or continuation of) REQ, so DRAIN holds it.
    assign mem_addr_d = (state_d == StReq) ? fetch_pc_d : mem_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_ADDR;
            mem_addr_q <= RESET_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= mem_data;
            exc_mem[wr_ptr_q]  <= mem_exc;
        end
    end

    always_comb begin
        inst_pc   = '0;
        inst_data = '0;
        inst_exc  = 1'b0;
        if (bypass) begin
            inst_pc   = fetch_pc_q;
            inst_data = mem_data;
            inst_exc  = mem_exc;
        end else if (!fifo_empty) begin
            inst_pc   = pc_mem[rd_ptr_q];
            inst_data = data_mem[rd_ptr_q];
            inst_exc  = exc_mem[rd_ptr_q];
        end
    end

    assign queue_count = count_q;

endmodule
